// File: rtl/eth_phy_10g_rx_block_sync.sv
// 64b/66b block aligner for the 10G PHY RX path: barrel-shifts raw SERDES words
// onto the block boundary and runs the sync-header lock state machine.
module eth_phy_10g_rx_block_sync #(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned HDR_WIDTH     = 2,
  parameter int unsigned LOCK_COUNT    = 64,
  parameter int unsigned SH_WINDOW     = 64,
  parameter int unsigned INVALID_LIMIT = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH+HDR_WIDTH-1:0] i_serdes_rx,
  output logic [DATA_WIDTH-1:0]           o_serdes_rx_data,
  output logic [HDR_WIDTH-1:0]            o_serdes_rx_hdr,
  output logic                            o_rx_valid,
  output logic                            o_rx_block_lock,
  output logic                            o_slip_pulse,
  output logic [6:0]                      o_slip_offset
);

  localparam int unsigned FRAME_WIDTH = DATA_WIDTH + HDR_WIDTH;
  localparam int unsigned OFF_W       = 7;
  localparam int unsigned SH_W        = 7;
  localparam int unsigned INV_W       = 5;
  localparam int unsigned IDX_W       = 8;
  localparam logic [OFF_W-1:0] OFF_MAX = OFF_W'(FRAME_WIDTH - 1);

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    SEARCH = 2'd1,
    SLIP   = 2'd2,
    LOCKED = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [FRAME_WIDTH-1:0]   prev_q;
  logic [SH_W-1:0]          sh_cnt_q, sh_cnt_d;
  logic [INV_W-1:0]         inv_cnt_q, inv_cnt_d;
  logic [OFF_W-1:0]         offset_d;
  logic [2*FRAME_WIDTH-1:0] cat;
  logic [IDX_W-1:0]         idx;
  logic [FRAME_WIDTH-1:0]   win;
  logic                     hdr_ok;

  // Barrel shifter: the block may straddle the previous and current SERDES words
  always_comb begin
    cat    = {i_serdes_rx, prev_q};
    idx    = IDX_W'(o_slip_offset);
    win    = cat[idx +: FRAME_WIDTH];
    hdr_ok = (win[HDR_WIDTH-1:0] == 2'b01) || (win[HDR_WIDTH-1:0] == 2'b10);
  end

  // Lock state machine: next state, counters and alignment offset
  always_comb begin
    state_d   = state_q;
    sh_cnt_d  = sh_cnt_q;
    inv_cnt_d = inv_cnt_q;
    offset_d  = o_slip_offset;
    unique case (state_q)
      INIT: begin
        state_d   = SEARCH;
        sh_cnt_d  = '0;
        inv_cnt_d = '0;
      end
      SEARCH: begin
        if (hdr_ok) begin
          if (sh_cnt_q == SH_W'(LOCK_COUNT - 1)) begin
            state_d  = LOCKED;
            sh_cnt_d = '0;
          end else begin
            sh_cnt_d = sh_cnt_q + SH_W'(1);
          end
        end else begin
          state_d   = SLIP;
          sh_cnt_d  = '0;
          inv_cnt_d = '0;
        end
      end
      SLIP: begin
        offset_d  = (o_slip_offset == OFF_MAX) ? '0 : o_slip_offset + OFF_W'(1);
        sh_cnt_d  = '0;
        inv_cnt_d = '0;
        state_d   = SEARCH;
      end
      LOCKED: begin
        // Loss of lock takes priority over the end-of-window clear
        if (!hdr_ok && (inv_cnt_q == INV_W'(INVALID_LIMIT - 1))) begin
          state_d   = SLIP;
          sh_cnt_d  = '0;
          inv_cnt_d = '0;
        end else if (sh_cnt_q == SH_W'(SH_WINDOW - 1)) begin
          sh_cnt_d  = '0;
          inv_cnt_d = '0;
        end else begin
          sh_cnt_d = sh_cnt_q + SH_W'(1);
          if (!hdr_ok) begin
            inv_cnt_d = inv_cnt_q + INV_W'(1);
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= INIT;
      prev_q           <= '0;
      sh_cnt_q         <= '0;
      inv_cnt_q        <= '0;
      o_slip_offset    <= '0;
      o_serdes_rx_data <= '0;
      o_serdes_rx_hdr  <= '0;
      o_rx_valid       <= 1'b0;
      o_rx_block_lock  <= 1'b0;
      o_slip_pulse     <= 1'b0;
    end else begin
      state_q          <= state_d;
      prev_q           <= i_serdes_rx;
      sh_cnt_q         <= sh_cnt_d;
      inv_cnt_q        <= inv_cnt_d;
      o_slip_offset    <= offset_d;
      o_serdes_rx_data <= win[FRAME_WIDTH-1:HDR_WIDTH];
      o_serdes_rx_hdr  <= win[HDR_WIDTH-1:0];
      o_rx_valid       <= (state_d == LOCKED);
      o_rx_block_lock  <= (state_d == LOCKED);
      o_slip_pulse     <= (state_d == SLIP);
    end
  end

endmodule

// File: tb/tb_eth_phy_10g_rx_block_sync.sv
// Directed bench for eth_phy_10g_rx_block_sync: aligned/rotated streams, header
// corruption around the loss-of-lock limit, offset wrap and mid-run reset.
module tb_eth_phy_10g_rx_block_sync;

  logic        clk = 1'b0;
  logic        rst;
  logic [65:0] serdes;
  logic [63:0] rx_data;
  logic [1:0]  rx_hdr;
  logic        rx_valid;
  logic        rx_lock;
  logic        slip_pulse;
  logic [6:0]  slip_offset;

  always #5 clk = ~clk;

  eth_phy_10g_rx_block_sync dut (
    .clk              (clk),
    .rst              (rst),
    .i_serdes_rx      (serdes),
    .o_serdes_rx_data (rx_data),
    .o_serdes_rx_hdr  (rx_hdr),
    .o_rx_valid       (rx_valid),
    .o_rx_block_lock  (rx_lock),
    .o_slip_pulse     (slip_pulse),
    .o_slip_offset    (slip_offset)
  );

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc;
  int          rot;
  int          pulse_cnt;
  int          last_pulse_cyc;
  int          lock_cyc;
  int          lk;
  logic [63:0] lfsr;
  logic [65:0] prev_blk;
  logic        prev_pulse;
  logic        prev_lock;
  logic [6:0]  prev_off;
  logic        rst_edge;
  logic        saw_wrap;

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Serial stream with block boundaries rot bits into each received word
  function automatic logic [65:0] make_word(input logic [65:0] blk, input logic [65:0] pblk,
                                            input int r);
    logic [131:0] c;
    c = {blk, pblk} >> (66 - r);
    return c[65:0];
  endfunction

  task automatic step(input bit corrupt);
    logic [65:0] blk;
    lfsr = lfsr ^ (lfsr << 13);
    lfsr = lfsr ^ (lfsr >> 7);
    lfsr = lfsr ^ (lfsr << 17);
    blk = {lfsr, corrupt ? 2'b00 : 2'b01};
    serdes = make_word(blk, prev_blk, rot);
    rst_edge = rst;
    @(posedge clk);
    #1;
    cyc++;
    if (rx_valid) check("data_hdr", {rx_data, rx_hdr}, prev_blk);
    if (slip_pulse) begin
      pulse_cnt++;
      last_pulse_cyc = cyc;
      check("no_b2b_pulse", 66'(prev_pulse), 66'd0);
    end
    if (!rst_edge && (slip_offset != prev_off)) begin
      check("offset_step", 66'(slip_offset), (prev_off == 7'd65) ? 66'd0 : 66'(prev_off) + 66'd1);
      if (prev_off == 7'd65) saw_wrap = 1'b1;
    end
    if (rx_lock && !prev_lock) lock_cyc = cyc;
    prev_blk   = blk;
    prev_pulse = slip_pulse;
    prev_off   = slip_offset;
    prev_lock  = rx_lock;
  endtask

  task automatic wait_lock(input string tag, input int budget);
    int n;
    n = 0;
    while (!rx_lock && n < budget) begin
      step(1'b0);
      n++;
    end
    check(tag, 66'(rx_lock), 66'd1);
  endtask

  initial begin
    rst = 1'b1;
    serdes = '0;
    rot = 0;
    cyc = 0;
    lfsr = 64'h0123_4567_89AB_CDEF;
    prev_blk = '0;
    prev_pulse = 1'b0;
    prev_lock = 1'b0;
    prev_off = '0;
    saw_wrap = 1'b0;
    pulse_cnt = 0;
    last_pulse_cyc = 0;
    lock_cyc = 0;
    repeat (3) step(1'b0);
    check("rst_data", 66'(rx_data), 66'd0);
    check("rst_hdr", 66'(rx_hdr), 66'd0);
    check("rst_valid", 66'(rx_valid), 66'd0);
    check("rst_lock", 66'(rx_lock), 66'd0);
    check("rst_pulse", 66'(slip_pulse), 66'd0);
    check("rst_offset", 66'(slip_offset), 66'd0);

    // Aligned stream: 1 INIT + 64 tests
    rst = 1'b0;
    cyc = 0;
    pulse_cnt = 0;
    repeat (64) step(1'b0);
    check("t1_lock_edge64", 66'(rx_lock), 66'd0);
    check("t1_valid_edge64", 66'(rx_valid), 66'd0);
    step(1'b0);
    check("t1_lock_edge65", 66'(rx_lock), 66'd1);
    check("t1_valid_edge65", 66'(rx_valid), 66'd1);
    check("t1_no_pulse", 66'(pulse_cnt), 66'd0);
    check("t1_offset", 66'(slip_offset), 66'd0);
    lk = cyc;

    // 15 bad headers in window 1 and 15 more in window 2: lock holds
    for (int e = lk + 1; e <= lk + 127; e++)
      step((e <= lk + 15) || (e >= lk + 64 && e <= lk + 78));
    check("t3_lock_held", 66'(rx_lock), 66'd1);
    check("t3_no_pulse", 66'(pulse_cnt), 66'd0);

    // 16 bad headers, the last on the 64th header of window 3
    for (int e = lk + 128; e <= lk + 191; e++)
      step(e >= lk + 176);
    check("t4_lock_before_16th", 66'(rx_lock), 66'd1);
    step(1'b0);
    check("t4_lock_drop", 66'(rx_lock), 66'd0);
    check("t4_valid_drop", 66'(rx_valid), 66'd0);
    check("t4_pulse", 66'(slip_pulse), 66'd1);
    check("t4_offset_hold", 66'(slip_offset), 66'd0);
    step(1'b0);
    check("t4_pulse_end", 66'(slip_pulse), 66'd0);
    check("t4_offset_inc", 66'(slip_offset), 66'd1);

    // Search sweeps up through 65, wraps to 0 and relocks there
    saw_wrap = 1'b0;
    wait_lock("t5_relock", 3000);
    check("t5_wrap_seen", 66'(saw_wrap), 66'd1);
    check("t5_offset", 66'(slip_offset), 66'd0);
    check("t5_lock_latency", 66'(lock_cyc - last_pulse_cyc), 66'd65);

    // Stream rotated by 37 bits, fresh start
    rst = 1'b1;
    rot = 37;
    repeat (2) step(1'b0);
    rst = 1'b0;
    cyc = 0;
    pulse_cnt = 0;
    wait_lock("t2_lock", 3000);
    check("t2_offset", 66'(slip_offset), 66'd37);
    check("t2_pulses", 66'(pulse_cnt), 66'd37);
    check("t2_lock_latency", 66'(lock_cyc - last_pulse_cyc), 66'd65);
    repeat (10) step(1'b0);

    // One-cycle reset while locked at 37
    rst = 1'b1;
    step(1'b0);
    check("t6_lock", 66'(rx_lock), 66'd0);
    check("t6_valid", 66'(rx_valid), 66'd0);
    check("t6_offset", 66'(slip_offset), 66'd0);
    check("t6_data", 66'(rx_data), 66'd0);
    check("t6_hdr", 66'(rx_hdr), 66'd0);
    check("t6_pulse", 66'(slip_pulse), 66'd0);
    rst = 1'b0;
    pulse_cnt = 0;
    wait_lock("t6_relock", 3000);
    check("t6_relock_offset", 66'(slip_offset), 66'd37);
    check("t6_pulses", 66'(pulse_cnt), 66'd37);
    repeat (5) step(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
